// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the shared-memory
// arbiter bundled into one interface.
//   slave  - arbiter view (consumes requests and memory responses)
//   master - environment view (issues requests, plays the backing memory)
interface mem_arbiter_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [CHANNELS-1:0]        req_rd;
    logic [CHANNELS-1:0]        req_wd;
    logic [CHANNELS*ADDR_W-1:0] req_addr;
    logic [CHANNELS*DATA_W-1:0] req_wdata;
    logic [CHANNELS*DATA_W-1:0] rsp_data;
    logic [CHANNELS-1:0]        rsp_wait;
    logic [CHANNELS-1:0]        rsp_segv;
    logic                       mem_req;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       mem_ack;
    logic [DATA_W-1:0]          mem_rdata;

    modport slave (
        input  req_rd, req_wd, req_addr, req_wdata, mem_ack, mem_rdata,
        output rsp_data, rsp_wait, rsp_segv, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_rd, req_wd, req_addr, req_wdata, mem_ack, mem_rdata,
        input  rsp_data, rsp_wait, rsp_segv, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving CHANNELS requesters one at a time
// access to a single backing memory.
//
// Optional feature: define MEM_SEGV_CHECK_EN to fault any grant whose address
// is >= LIMIT. A faulting grant never reaches memory; it goes straight to DONE
// with rsp_segv raised for the granted channel. Without the macro rsp_segv is
// tied low and every address is forwarded. The limit compare is done at 64
// bits, so ADDR_W is expected to be at most 64.
//
// state | meaning
// IDLE  | sample requests, pick next channel after the last grant
// BUSY  | memory access in flight, mem_req held until mem_ack
// DONE  | one-cycle completion; rsp_wait of the granted channel drops
module mem_arbiter #(
    parameter int          CHANNELS = 2,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] LIMIT    = 32'h0001_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("mem_arbiter: CHANNELS must be within 1..8");
    end
    if (LIMIT == 32'd0) begin : g_bad_limit
        $error("mem_arbiter: a LIMIT of zero would reject every address");
    end

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [DATA_W-1:0]   rsp_data_q [CHANNELS];

    logic [CHANNELS-1:0] req_any;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_wdata;
    logic                grant_we;
    logic                grant_fault;

    assign req_any = bus.req_rd | bus.req_wd;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % CHANNELS);
            if (!grant_found && req_any[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Read and write both set on one channel resolve to a write.
    assign grant_addr  = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign grant_wdata = bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    assign grant_we    = bus.req_wd[grant_idx];

`ifdef MEM_SEGV_CHECK_EN
    assign grant_fault = (64'(grant_addr) >= 64'(LIMIT));
`else
    assign grant_fault = 1'b0;
`endif

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_nxt = grant_fault ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the grant snapshot that drives memory during BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr_q   <= PTR_W'(CHANNELS - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_found) begin
                ptr_q   <= grant_idx;
                grant_q <= grant_idx;
                addr_q  <= grant_addr;
                wdata_q <= grant_wdata;
                we_q    <= grant_we;
            end
        end
    end

    // Load data lands in the granted channel's register only on a read ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else if (state == BUSY && bus.mem_ack && !we_q) begin
            rsp_data_q[grant_q] <= bus.mem_rdata;
        end
    end

`ifdef MEM_SEGV_CHECK_EN
    logic fault_q;

    // Remember whether the current grant faulted so DONE can flag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (state == IDLE && grant_found) begin
            fault_q <= grant_fault;
        end
    end
`endif

    assign bus.mem_req   = (state == BUSY);
    assign bus.mem_we    = (state == BUSY) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign bus.rsp_data[i*DATA_W +: DATA_W] = rsp_data_q[i];
        assign bus.rsp_wait[i] = req_any[i] && !(state == DONE && int'(grant_q) == i);
`ifdef MEM_SEGV_CHECK_EN
        assign bus.rsp_segv[i] = (state == DONE) && fault_q && (int'(grant_q) == i);
`else
        assign bus.rsp_segv[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (2 channels).
// Stimulus pushes expected completions and expected memory accesses into
// queues; a monitor and a memory responder pop and compare independently.
module tb_mem_arbiter;

    localparam int CH = 2;

    typedef struct {
        int          ch;
        logic        rd;
        logic        wd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } mem_t;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        segv;
        int          lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.CHANNELS(CH), .ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .CHANNELS(CH),
        .ADDR_W  (32),
        .DATA_W  (32),
        .LIMIT   (32'h0001_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    req_t reqs[$];
    mem_t mem_q[$];
    exp_t exp_q[$];

    logic [CH-1:0] done_flag  = '0;
    logic [CH-1:0] presenting = '0;
    int            issue_cyc [CH];
    logic          mem_auto   = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int ch, input logic rd, input logic wd,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay, input logic to_mem,
                         input logic [31:0] exp_data, input logic exp_segv, input int exp_lat);
        req_t r;
        mem_t m;
        exp_t e;
        r.ch = ch; r.rd = rd; r.wd = wd; r.addr = addr; r.wdata = wdata;
        reqs.push_back(r);
        if (to_mem) begin
            m.addr = addr; m.we = wd; m.wdata = wdata; m.rdata = rdata; m.delay = delay;
            mem_q.push_back(m);
        end
        e.ch = ch; e.data = exp_data; e.segv = exp_segv; e.lat = exp_lat;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((reqs.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_pending", 64'(reqs.size() + exp_q.size()), 64'd0);
        repeat (2) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Requesters: present each channel's oldest entry until it completes.
    initial begin : p_req
        int  idx;
        bit  removed;
        forever begin
            @(posedge clk); #1;
            for (int ch = 0; ch < CH; ch++) begin
                if (done_flag[ch]) begin
                    done_flag[ch]  = 1'b0;
                    presenting[ch] = 1'b0;
                    removed = 1'b0;
                    for (int j = 0; j < reqs.size(); j++) begin
                        if (!removed && reqs[j].ch == ch) begin
                            reqs.delete(j);
                            removed = 1'b1;
                        end
                    end
                end
                idx = -1;
                for (int j = reqs.size() - 1; j >= 0; j--) begin
                    if (reqs[j].ch == ch) idx = j;
                end
                if (idx >= 0) begin
                    bus.req_rd[ch]             = reqs[idx].rd;
                    bus.req_wd[ch]             = reqs[idx].wd;
                    bus.req_addr[ch*32 +: 32]  = reqs[idx].addr;
                    bus.req_wdata[ch*32 +: 32] = reqs[idx].wdata;
                    if (!presenting[ch]) begin
                        presenting[ch] = 1'b1;
                        issue_cyc[ch]  = cyc;
                    end
                end else begin
                    bus.req_rd[ch] = 1'b0;
                    bus.req_wd[ch] = 1'b0;
                end
            end
        end
    end

    // Backing memory: checks each access against the expected queue, acks after its delay.
    initial begin : p_mem
        mem_t cur;
        bit   in_txn;
        bit   drop_check;
        int   cnt;
        int   unstable;
        in_txn = 1'b0; drop_check = 1'b0; cnt = 0; unstable = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_auto) begin
                bus.mem_ack = 1'b0;
                if (drop_check) begin
                    check("mem_req_after_ack", 64'(bus.mem_req), 64'd0);
                    drop_check = 1'b0;
                end
                if (bus.mem_req) begin
                    if (!in_txn) begin
                        if (mem_q.size() == 0) begin
                            check("mem_req_unexpected", 64'(bus.mem_req), 64'd0);
                        end else begin
                            cur = mem_q.pop_front();
                            in_txn = 1'b1; cnt = 0; unstable = 0;
                        end
                    end
                    if (in_txn) begin
                        if (bus.mem_addr !== cur.addr || bus.mem_we !== cur.we ||
                            (cur.we && bus.mem_wdata !== cur.wdata))
                            unstable++;
                        if (cnt == cur.delay) begin
                            check("mem_addr", 64'(bus.mem_addr), 64'(cur.addr));
                            check("mem_we", 64'(bus.mem_we), 64'(cur.we));
                            if (cur.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
                            check("mem_unstable_cycles", 64'(unstable), 64'd0);
                            bus.mem_ack   = 1'b1;
                            bus.mem_rdata = cur.rdata;
                            in_txn        = 1'b0;
                            drop_check    = 1'b1;
                        end
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: a held request with rsp_wait low is a completion; compare against the scoreboard.
    initial begin : p_mon
        exp_t          e;
        logic [CH-1:0] done_mask;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                done_mask = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    if ((bus.req_rd[ch] | bus.req_wd[ch]) && !bus.rsp_wait[ch]) begin
                        done_mask[ch] = 1'b1;
                        done_flag[ch] = 1'b1;
                        if (exp_q.size() == 0) begin
                            check("done_unexpected_chan", 64'(ch), 64'hFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("done_chan", 64'(ch), 64'(e.ch));
                            check("rsp_data", 64'(bus.rsp_data[ch*32 +: 32]), 64'(e.data));
                            check("rsp_segv", 64'(bus.rsp_segv[ch]), 64'(e.segv));
                            if (e.lat >= 0) check("latency", 64'(cyc - issue_cyc[ch]), 64'(e.lat));
                        end
                    end
                end
                check("segv_stray", 64'(bus.rsp_segv & ~done_mask), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_rd    = '0;
        bus.req_wd    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_rsp_segv", 64'(bus.rsp_segv), 64'd0);
        check("rst_rsp_wait", 64'(bus.rsp_wait), 64'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
        end

        // Minimum-latency read on channel 0.
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
        drain(40);

        // Channel 1 write held four BUSY cycles; its load register stays at reset value.
        issue(1, 1'b0, 1'b1, 32'h20, 32'h55, 32'hBAADF00D, 3, 1'b1, 32'h0, 1'b0, 5);
        drain(40);

        // Both channels back to back: grants alternate 0,1,0,1.
        issue(0, 1'b1, 1'b0, 32'h100, 32'h0,  32'h11110000, 0, 1'b1, 32'h11110000, 1'b0, 2);
        issue(1, 1'b1, 1'b0, 32'h104, 32'h0,  32'h22220001, 0, 1'b1, 32'h22220001, 1'b0, 5);
        issue(0, 1'b0, 1'b1, 32'h108, 32'h33, 32'hBAADF00D, 0, 1'b1, 32'h11110000, 1'b0, 5);
        issue(1, 1'b1, 1'b1, 32'h10C, 32'h44, 32'hBAADF00D, 0, 1'b1, 32'h22220001, 1'b0, 5);
        drain(80);

        // Reset in the middle of a BUSY access, then a stale ack.
        mem_auto    = 1'b0;
        bus.mem_ack = 1'b0;
        begin
            req_t r;
            int   n;
            r.ch = 1; r.rd = 1'b1; r.wd = 1'b0; r.addr = 32'h40; r.wdata = 32'h0;
            reqs.push_back(r);
            n = 0;
            while (!bus.mem_req && n < 10) begin
                @(posedge clk); #2;
                n++;
            end
            check("busy_reached", 64'(bus.mem_req), 64'd1);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_busy_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_busy_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_busy_rsp_data", bus.rsp_data, 64'd0);
        reqs.delete();
        presenting = '0;
        done_flag  = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        repeat (2) begin
            @(posedge clk); #2;
            check("late_ack_mem_req", 64'(bus.mem_req), 64'd0);
            check("late_ack_rsp_wait", 64'(bus.rsp_wait), 64'd0);
        end
        bus.mem_ack = 1'b0;
        mem_auto    = 1'b1;
        @(posedge clk); #2;
        check("late_ack_rsp_data", bus.rsp_data, 64'd0);

        // After reset channel 0 wins a simultaneous request.
        issue(0, 1'b1, 1'b0, 32'h30, 32'h0,  32'hA5A50000, 0, 1'b1, 32'hA5A50000, 1'b0, 2);
        issue(1, 1'b0, 1'b1, 32'h34, 32'h77, 32'hBAADF00D, 0, 1'b1, 32'h0,        1'b0, 5);
        drain(60);

        // Address limit boundary: last legal address, then the first illegal one.
        issue(0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0, 32'h0F0F0F0F, 0, 1'b1, 32'h0F0F0F0F, 1'b0, 2);
`ifdef MEM_SEGV_CHECK_EN
        issue(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'h12345678, 0, 1'b0, 32'h0F0F0F0F, 1'b1, 1);
`else
        issue(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'h12345678, 0, 1'b1, 32'h12345678, 1'b0, 2);
`endif
        drain(40);

        check("mem_q_left", 64'(mem_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of requester channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter LIMIT, default 32'h0001_0000, first illegal address.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_rd, input, CHANNELS, per-channel read request.
REQ-008 SHALL have port req_wd, input, CHANNELS, per-channel write request.
REQ-009 SHALL have port req_addr, input, CHANNELS*ADDR_W, per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata, input, CHANNELS*DATA_W, per-channel store data.
REQ-011 SHALL have port rsp_data, output, CHANNELS*DATA_W, per-channel registered load data.
REQ-012 SHALL have port rsp_wait, output, CHANNELS, high while channel i has an uncompleted request.
REQ-013 SHALL have port rsp_segv, output, CHANNELS, one-cycle fault flag for channel i.
REQ-014 SHALL have port mem_req, output, 1, backing-memory request.
REQ-015 SHALL have port mem_we, output, 1, backing-memory write enable.
REQ-016 SHALL have ports mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), memory address and store data.
REQ-017 SHALL have ports mem_ack (input, 1) and mem_rdata (input, DATA_W), memory completion and load data.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-019 In IDLE with any channel requesting (req_rd|req_wd), SHALL grant the first requesting channel strictly after last-granted pointer, wrapping modulo CHANNELS, and register grant index, address, write flag and wdata.
REQ-020 IDLE -> BUSY on a legal grant; mem_req=1 and mem_addr/mem_we/mem_wdata driven from registers for every BUSY cycle.
REQ-021 BUSY holds until mem_ack=1; then, for a read, SHALL capture mem_rdata into rsp_data of the granted channel and go to DONE.
REQ-022 DONE lasts exactly one cycle, then IDLE; rsp_wait[grant]=0 in DONE.
REQ-023 rsp_wait[i] SHALL equal (req_rd[i]|req_wd[i]) and not (state==DONE and grant==i).
REQ-024 Minimum latency: request in cycle 0 (IDLE), mem_req in cycle 1, mem_ack in cycle 1 gives rsp_wait low in cycle 2.
REQ-025 req_rd and req_wd both high on one channel SHALL be treated as a write.
REQ-026 rsp_data of a channel SHALL hold its value until that channel's next completed read; writes leave it unchanged.
REQ-027 Requester SHALL hold its request stable until rsp_wait drops; arbiter samples inputs only in IDLE.
REQ-028 mem_ack outside BUSY SHALL be ignored.
REQ-029 Pointer SHALL update to the granted index on every grant, legal or faulting.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_data=0, rsp_segv=0, pointer=CHANNELS-1 (channel 0 first).
REQ-031 Reset during BUSY SHALL abandon the memory transaction; late mem_ack after release is ignored (REQ-028).

Configuration
REQ-032 With MEM_SEGV_CHECK_EN defined, a grant whose address >= LIMIT SHALL skip BUSY (IDLE -> DONE), assert mem_req never, set rsp_segv[grant]=1 during DONE only, and leave rsp_data unchanged.
REQ-033 Without MEM_SEGV_CHECK_EN, rsp_segv SHALL be constant 0 and every address SHALL be forwarded to memory.

Verification
REQ-034 Channel 0 reads 0x10, memory acks in BUSY cycle 1 with 0xDEADBEEF -> rsp_wait[0] low in cycle 2, rsp_data[0]=0xDEADBEEF.
REQ-035 Channels 0 and 1 request together, repeated each completion -> grants alternate 0,1,0,1; no channel waits more than one other transaction.
REQ-036 Channel 1 writes 0x55 to 0x20 with mem_ack delayed 4 cycles -> mem_req, mem_we, mem_addr=0x20, mem_wdata=0x55 stable 4 cycles, rsp_data[1] unchanged.
REQ-037 With MEM_SEGV_CHECK_EN, channel 0 reads 0x0001_0000 -> no mem_req, rsp_segv[0]=1 for one cycle, rsp_wait[0] low same cycle; without macro the access reaches memory.
REQ-038 rst_n pulsed low in BUSY, then mem_ack -> mem_req=0 immediately, state IDLE, ack ignored, next grant channel 0.
